// File: rtl/seg_hc595_scan.sv
// Multiplexed seven-segment scanner for 74HC595-chained display boards.
// Shifts one 16-bit {segments, digit-select} word per digit, latches it, then holds it on display.
module seg_hc595_scan #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 4,
    parameter int SCAN_HOLD      = 2000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_blank,
    input  logic [3:0]            brightness,
    output logic                  clk,
    output logic                  dat,
    output logic                  str,
    output logic                  frame_done
);

    localparam int CNT_MAX = (CLK_DIV > SCAN_HOLD) ? CLK_DIV : SCAN_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(SCAN_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        LATCH,
        HOLD
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0]       cnt;
    logic [3:0]          bit_cnt;
    logic                phase;
    logic [IW-1:0]       idx;
    logic [3:0]          frame_cnt;
    logic [15:0]         shreg;
    logic                dat_reg;

    logic [4*DIGITS-1:0] snap_data;
    logic [DIGITS-1:0]   snap_dp;
    logic [DIGITS-1:0]   snap_blank;
    logic                snap_lz;
    logic [3:0]          snap_bright;

    logic [4*DIGITS-1:0] cur_data;
    logic [DIGITS-1:0]   cur_dp;
    logic [DIGITS-1:0]   cur_blank;
    logic                cur_lz;
    logic [3:0]          cur_bright;

    logic                cnt_done;
    logic                last_bit;
    logic [3:0]          nib;
    logic                upper_zero;
    logic                lit;
    logic                dark;
    logic [7:0]          seg;
    logic [7:0]          sel;
    logic [15:0]         word;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Digit 0 reads the live inputs in the same cycle they are snapshotted, so the whole frame is consistent.
    assign cur_data   = (idx == '0) ? data       : snap_data;
    assign cur_dp     = (idx == '0) ? dp         : snap_dp;
    assign cur_blank  = (idx == '0) ? blank      : snap_blank;
    assign cur_lz     = (idx == '0) ? lz_blank   : snap_lz;
    assign cur_bright = (idx == '0) ? brightness : snap_bright;

    assign cnt_done = (state == HOLD) ? (cnt == HOLD_LAST) : (cnt == DIV_LAST);
    assign last_bit = (bit_cnt == 4'd15);

    always_comb begin
        nib        = 4'h0;
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (j == int'(idx)) nib = cur_data[4*j +: 4];
            if (j >= int'(idx) && cur_data[4*j +: 4] != 4'h0) upper_zero = 1'b0;
        end
    end

    always_comb begin
        lit  = (cur_bright == 4'hF) || (frame_cnt < cur_bright);
        dark = cur_blank[idx] || (cur_lz && (idx != '0) && upper_zero) || !lit;
        seg  = dark ? 8'h00 : {cur_dp[idx], hex7(nib)};
        sel  = 8'd1 << idx;
        if (SEG_ACTIVE_LOW) seg = ~seg;
        if (DIG_ACTIVE_LOW) sel = ~sel;
        word = {seg, sel};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= LOAD;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:  next_state = SHIFT;
            SHIFT: if (cnt_done && phase && last_bit) next_state = LATCH;
            LATCH: if (cnt_done) next_state = HOLD;
            HOLD:  if (cnt_done) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_comb begin
        clk        = (state == SHIFT) && phase;
        str        = (state == LATCH);
        dat        = dat_reg;
        frame_done = (state == HOLD) && cnt_done && (idx == IDX_LAST);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt         <= '0;
            bit_cnt     <= 4'd0;
            phase       <= 1'b0;
            idx         <= '0;
            frame_cnt   <= 4'd0;
            shreg       <= 16'h0000;
            dat_reg     <= 1'b0;
            snap_data   <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_lz     <= 1'b0;
            snap_bright <= 4'd0;
        end else begin
            cnt <= (state == LOAD || cnt_done) ? '0 : cnt + CW'(1);
            case (state)
                LOAD: begin
                    shreg   <= word;
                    dat_reg <= word[15];
                    bit_cnt <= 4'd0;
                    phase   <= 1'b0;
                    if (idx == '0) begin
                        snap_data   <= data;
                        snap_dp     <= dp;
                        snap_blank  <= blank;
                        snap_lz     <= lz_blank;
                        snap_bright <= brightness;
                    end
                end
                SHIFT: begin
                    if (cnt_done) begin
                        phase <= ~phase;
                        // Next bit is presented as the low phase begins.
                        if (phase && !last_bit) begin
                            shreg   <= {shreg[14:0], 1'b0};
                            dat_reg <= shreg[14];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        if (idx == IDX_LAST) begin
                            idx       <= '0;
                            frame_cnt <= frame_cnt + 4'd1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_hc595_scan.sv
// Randomized scoreboard bench for seg_hc595_scan: a serial-capture monitor checks each latched
// word against an arithmetic display model, plus digit/frame periods and reset behaviour.
module tb_seg_hc595_scan;

    localparam int DIGITS    = 4;
    localparam int CLK_DIV   = 2;
    localparam int SCAN_HOLD = 12;
    localparam int DIGIT_PER = 1 + 33 * CLK_DIV + SCAN_HOLD;
    localparam int FRAME_PER = DIGITS * DIGIT_PER;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic        lz_blank = 1'b0;
    logic [3:0]  brightness = 4'h0;
    logic        clk;
    logic        dat;
    logic        str;
    logic        frame_done;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          model_frame = 0;
    logic [15:0] exp_q[$];

    logic [15:0] cap;
    logic [15:0] exp_w;
    int          nbits;
    logic        prev_clk;
    logic        prev_str;
    logic        prev_fd;
    int          last_str;
    int          last_fd;

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    seg_hc595_scan #(
        .DIGITS(DIGITS),
        .CLK_DIV(CLK_DIV),
        .SCAN_HOLD(SCAN_HOLD),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .data(data),
        .dp(dp),
        .blank(blank),
        .lz_blank(lz_blank),
        .brightness(brightness),
        .clk(clk),
        .dat(dat),
        .str(str),
        .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Display word for digit i of a frame, straight from the display rules (common-anode segments).
    function automatic logic [15:0] model_word(input logic [15:0] d, input logic [3:0] dpv,
                                               input logic [3:0] bl, input logic lz,
                                               input logic [3:0] br, input int frame, input int i);
        logic [7:0] seg;
        logic [7:0] sel;
        int         nib;
        bit         dark;
        nib  = int'((d >> (4 * i)) & 16'h000F);
        dark = bl[i] || (lz && i > 0 && (d >> (4 * i)) == 16'd0) ||
               !(br == 4'd15 || (frame % 16) < int'(br));
        seg  = dark ? 8'h00 : {dpv[i], seg_tab[nib][6:0]};
        seg  = ~seg;
        sel  = 8'(1 << i);
        return {seg, sel};
    endfunction

    task automatic push_frame();
        for (int i = 0; i < DIGITS; i++)
            exp_q.push_back(model_word(data, dp, blank, lz_blank, brightness, model_frame, i));
    endtask

    task automatic wait_frame_done();
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!frame_done && n < 2 * FRAME_PER);
        if (!frame_done) begin
            checks++;
            fails++;
            $display("[TB] FAIL frame_done_timeout: got no pulse, want one within %0d cycles", 2 * FRAME_PER);
        end
    endtask

    // Scrambles inputs mid-frame (must not tear), then installs the next frame's values at frame end.
    task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl,
                                  input logic lz, input logic [3:0] br);
        int w;
        w = $urandom_range(FRAME_PER - 20, 3);
        repeat (w) @(negedge sys_clk);
        data       = 16'($urandom);
        dp         = 4'($urandom);
        blank      = 4'($urandom);
        lz_blank   = 1'($urandom);
        brightness = 4'($urandom);
        wait_frame_done();
        data       = d;
        dp         = dpv;
        blank      = bl;
        lz_blank   = lz;
        brightness = br;
        model_frame++;
        push_frame();
    endtask

    task automatic check_first_rise();
        int n = 0;
        do begin
            @(posedge sys_clk);
            #1;
            n++;
        end while (!clk && n < 50);
        check_output("first_clk_rise", 16'(n), 16'(1 + CLK_DIV));
    endtask

    always @(negedge sys_clk) begin
        cyc++;
        if (!sys_rst_n) begin
            cap      = 16'h0000;
            nbits    = 0;
            prev_clk = 1'b0;
            prev_str = 1'b0;
            prev_fd  = 1'b0;
            last_str = -1;
            last_fd  = -1;
        end else begin
            if (clk && !prev_clk) begin
                cap = {cap[14:0], dat};
                nbits++;
            end
            if (str && !prev_str) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL word: got %h, want none (queue empty)", cap);
                end else begin
                    exp_w = exp_q.pop_front();
                    check_output("word", cap, exp_w);
                end
                check_output("bits_per_word", 16'(nbits), 16'd16);
                if (last_str >= 0) check_output("digit_period", 16'(cyc - last_str), 16'(DIGIT_PER));
                last_str = cyc;
                nbits    = 0;
            end
            if (frame_done) begin
                check_output("frame_done_width", 16'(prev_fd), 16'd0);
                if (!prev_fd) begin
                    if (last_fd >= 0) check_output("frame_period", 16'(cyc - last_fd), 16'(FRAME_PER));
                    last_fd = cyc;
                end
            end
            prev_clk = clk;
            prev_str = str;
            prev_fd  = frame_done;
        end
    end

    initial begin
        #(200000 * 10);
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        data       = 16'h12AF;
        dp         = 4'h0;
        blank      = 4'h0;
        lz_blank   = 1'b0;
        brightness = 4'hF;
        repeat (3) @(negedge sys_clk);
        check_output("reset_clk", 16'(clk), 16'd0);
        check_output("reset_dat", 16'(dat), 16'd0);
        check_output("reset_str", 16'(str), 16'd0);
        check_output("reset_frame_done", 16'(frame_done), 16'd0);

        model_frame = 0;
        exp_q.delete();
        push_frame();
        sys_rst_n = 1'b1;
        check_first_rise();

        apply_stimulus(16'h0050, 4'h0, 4'h0, 1'b1, 4'hF);
        apply_stimulus(16'h0300, 4'h0, 4'h0, 1'b1, 4'hF);
        for (int f = 0; f < 16; f++)
            apply_stimulus(16'h8421, 4'b0101, 4'h0, 1'b0, 4'd4);
        for (int f = 0; f < 2; f++)
            apply_stimulus(16'h9C3E, 4'hF, 4'h0, 1'b0, 4'd0);
        apply_stimulus(16'h5A5A, 4'h0, 4'b0110, 1'b0, 4'hF);
        for (int f = 0; f < 8; f++)
            apply_stimulus(16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom),
                           1'($urandom), 4'($urandom));

        // Reset in the middle of a shift, while clk and dat are both high.
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!(clk && dat && dut.state != 2'd0) && n < FRAME_PER);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_output("async_reset_clk", 16'(clk), 16'd0);
        check_output("async_reset_dat", 16'(dat), 16'd0);
        check_output("async_reset_str", 16'(str), 16'd0);
        check_output("async_reset_frame_done", 16'(frame_done), 16'd0);
        exp_q.delete();
        data        = 16'hBEEF;
        dp          = 4'b0001;
        blank       = 4'h0;
        lz_blank    = 1'b0;
        brightness  = 4'd1;
        model_frame = 0;
        push_frame();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check_first_rise();

        for (int f = 0; f < 2; f++)
            apply_stimulus(16'($urandom), 4'($urandom), 4'h0, 1'b1, 4'd1);
        wait_frame_done();
        @(negedge sys_clk);
        check_output("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
